// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - shared board constants, position type, mover state encoding
//
// Purpose : common definitions for the board position counter and the
//           per-player token movers.
// Contents: TILES_C / POS_W_C board geometry, pos_t position type,
//           mover_state_t FSM encoding, next_pos() modulo-TILES increment.

package board_pkg;

  localparam int TILES_C = 24;
  localparam int POS_W_C = 5;

  typedef logic [POS_W_C-1:0] pos_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    ARRIVE = 2'd2
  } mover_state_t;

  // Wrap is an explicit compare against the last tile; the ring is not a
  // power of two, so natural overflow of the position bus would be wrong.
  function automatic pos_t next_pos(input pos_t p);
    if (p == pos_t'(TILES_C - 1)) begin
      return '0;
    end
    return p + pos_t'(1);
  endfunction

endpackage

// File: rtl/step_ticker.sv
// rtl/step_ticker.sv - clock divider producing one terminal-count pulse per token step
//
// Purpose : counts 0..DIV-1 while enabled and flags the last count so the
//           mover can advance exactly once every DIV cycles.
// Ports   : clk    in  system clock
//           rst_n  in  synchronous reset, active-low
//           clr    in  synchronous clear of the count (wins over en)
//           en     in  count enable
//           tc     out high during the cycle the count sits at DIV-1 while enabled

module step_ticker #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = en && (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/player_token_mover.sv
// rtl/player_token_mover.sv - walks one player's token around the LED ring to a requested tile
//
// Purpose : accepts a target tile and advances the token one tile per step
//           tick, forward only, wrapping from TILES-1 to 0.
// Ports   : clk        in  system clock
//           rst_n      in  synchronous reset, active-low
//           tgt_valid  in  one-cycle strobe, tgt_pos holds a new target
//           tgt_pos    in  requested target tile
//           cur_pos    out tile currently occupied by the token
//           led_ring   out one-hot of cur_pos
//           busy       out high while the token is moving
//           arrived    out one-cycle pulse when the target is reached
//           lap        out one-cycle pulse on each wrap TILES-1 -> 0

module player_token_mover
  import board_pkg::*;
#(
  parameter int TILES    = 24,
  parameter int POS_W    = 5,
  parameter int STEP_DIV = 25000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic [POS_W-1:0] tgt_pos,
  output logic [POS_W-1:0] cur_pos,
  output logic [TILES-1:0] led_ring,
  output logic             busy,
  output logic             arrived,
  output logic             lap
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(TILES - 1);

  mover_state_t     state;
  mover_state_t     state_nxt;
  logic [POS_W-1:0] target;
  logic [POS_W-1:0] pos_adv;
  logic             tgt_ok;
  logic             step_tc;

  assign tgt_ok  = (tgt_pos <= LAST_POS);
  assign pos_adv = (cur_pos == LAST_POS) ? '0 : cur_pos + 1'b1;

  // The ticker is held cleared outside MOVE, so every move starts from a
  // zero count and the first step lands STEP_DIV cycles after the strobe.
  step_ticker #(
    .DIV (STEP_DIV)
  ) u_step_ticker (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != MOVE),
    .en    (state == MOVE),
    .tc    (step_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (tgt_valid && tgt_ok) begin
          state_nxt = (tgt_pos == cur_pos) ? ARRIVE : MOVE;
        end
      end
      MOVE: begin
        // Strobes are not looked at here: a move always runs to its
        // latched target.
        if (step_tc && (pos_adv == target)) begin
          state_nxt = ARRIVE;
        end
      end
      ARRIVE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Position, LED ring and lap are registered together so they always
  // change on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_pos  <= '0;
      led_ring <= TILES'(1);
      target   <= '0;
      lap      <= 1'b0;
    end else begin
      lap <= 1'b0;
      if ((state == IDLE) && tgt_valid && tgt_ok && (tgt_pos != cur_pos)) begin
        target <= tgt_pos;
      end
      if (step_tc) begin
        cur_pos  <= pos_adv;
        led_ring <= TILES'(1) << pos_adv;
        lap      <= (cur_pos == LAST_POS);
      end
    end
  end

  assign busy    = (state == MOVE);
  assign arrived = (state == ARRIVE);

endmodule

// File: tb/tb_player_token_mover.sv
// tb/tb_player_token_mover.sv - self-checking bench for player_token_mover

module tb_player_token_mover;

  localparam int TILES    = 24;
  localparam int POS_W    = 5;
  localparam int STEP_DIV = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tgt_valid = 1'b0;
  logic [POS_W-1:0] tgt_pos = '0;
  logic [POS_W-1:0] cur_pos;
  logic [TILES-1:0] led_ring;
  logic             busy;
  logic             arrived;
  logic             lap;

  int checks = 0;
  int errors = 0;
  int model_pos = 0;

  always #5 clk = ~clk;

  player_token_mover #(
    .TILES    (TILES),
    .POS_W    (POS_W),
    .STEP_DIV (STEP_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tgt_valid (tgt_valid),
    .tgt_pos   (tgt_pos),
    .cur_pos   (cur_pos),
    .led_ring  (led_ring),
    .busy      (busy),
    .arrived   (arrived),
    .lap       (lap)
  );

  typedef struct {
    int tgt;
    int inj_k;
    int inj_pos;
    int fin;
    int steps;
    int laps;
    int arr;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Issues one target strobe, optionally a second strobe inj_k cycles later,
  // and watches every cycle until the move settles or the budget runs out.
  task automatic run_move(input string tag, input int tgt, input int inj_k,
                          input int inj_pos, input int exp_final,
                          input int exp_steps, input int exp_laps,
                          input int exp_arr);
    int steps, laps, arr, arr_k, last_k, first_k;
    int space_bad, inc_bad, lap_bad, busy_bad, led_bad;
    int prev, limit, lag;
    logic exp_busy;
    steps = 0; laps = 0; arr = 0; arr_k = -1; last_k = -1; first_k = -1;
    space_bad = 0; inc_bad = 0; lap_bad = 0; busy_bad = 0; led_bad = 0;
    limit = TILES * STEP_DIV + 20;
    @(negedge clk);
    prev = int'(cur_pos);
    tgt_pos = tgt[POS_W-1:0];
    tgt_valid = 1'b1;
    @(negedge clk);
    tgt_valid = 1'b0;
    for (int k = 0; k < limit; k++) begin
      if (k > 0) @(negedge clk);
      tgt_valid = (k == inj_k);
      if (k == inj_k) tgt_pos = inj_pos[POS_W-1:0];
      if (int'(cur_pos) != prev) begin
        steps++;
        if (first_k < 0) first_k = k;
        else if (k - last_k != STEP_DIV) space_bad++;
        if (int'(cur_pos) != (prev + 1) % TILES) inc_bad++;
        last_k = k;
        prev = int'(cur_pos);
      end else if (lap) begin
        lap_bad++;
      end
      if (led_ring !== (24'd1 << cur_pos)) led_bad++;
      if (lap) begin
        laps++;
        if (cur_pos != '0) lap_bad++;
      end
      if (arrived) begin
        arr++;
        if (arr_k < 0) arr_k = k;
      end
      exp_busy = (exp_steps > 0) && (arr == 0);
      if (busy !== exp_busy) busy_bad++;
      if (arr_k >= 0 && k >= arr_k + 3) break;
      if (exp_arr == 0 && k >= 12) break;
    end
    tgt_valid = 1'b0;
    check({tag, "_final"}, int'(cur_pos), exp_final);
    check({tag, "_steps"}, steps, exp_steps);
    check({tag, "_laps"}, laps, exp_laps);
    check({tag, "_arrived"}, arr, exp_arr);
    check({tag, "_led"}, int'(led_ring), 1 << exp_final);
    check({tag, "_led_track"}, led_bad, 0);
    check({tag, "_spacing"}, space_bad, 0);
    check({tag, "_increment"}, inc_bad, 0);
    check({tag, "_lap_place"}, lap_bad, 0);
    check({tag, "_busy"}, busy_bad, 0);
    if (exp_steps > 0) check({tag, "_first_step"}, first_k, STEP_DIV);
    if (exp_arr > 0) begin
      lag = arr_k - ((exp_steps > 0) ? last_k : 0);
      check({tag, "_arrive_timing"}, int'(lag == 0 || lag == 1), 1);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_lap, n_arr, n_busy, n_move, seen6;
    int tgt, steps, laps, fin, arr, inj_k, inj_pos;

    vecs[0]  = '{3,  -1, 0, 3,  3,  0, 1};
    vecs[1]  = '{3,   0, 9, 3,  0,  0, 1};
    vecs[2]  = '{25, -1, 0, 3,  0,  0, 0};
    vecs[3]  = '{22, -1, 0, 22, 19, 0, 1};
    vecs[4]  = '{1,  -1, 0, 1,  3,  1, 1};
    vecs[5]  = '{0,  -1, 0, 0,  23, 1, 1};
    vecs[6]  = '{5,  -1, 0, 5,  5,  0, 1};
    vecs[7]  = '{5,  -1, 0, 5,  0,  0, 1};
    vecs[8]  = '{10,  6, 2, 10, 5,  0, 1};
    vecs[9]  = '{24, -1, 0, 10, 0,  0, 0};
    vecs[10] = '{31, -1, 0, 10, 0,  0, 0};
    vecs[11] = '{10, -1, 0, 10, 0,  0, 1};

    // reset then idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_lap = 0; n_arr = 0; n_busy = 0; n_move = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (lap) n_lap++;
      if (arrived) n_arr++;
      if (busy) n_busy++;
      if (cur_pos != '0) n_move++;
    end
    check("reset_pos", int'(cur_pos), 0);
    check("reset_led", int'(led_ring), 1);
    check("reset_busy", n_busy, 0);
    check("reset_arrived", n_arr, 0);
    check("reset_lap", n_lap, 0);
    check("reset_motion", n_move, 0);

    // table-driven moves
    for (int i = 0; i < 12; i++) begin
      run_move($sformatf("vec%0d", i), vecs[i].tgt, vecs[i].inj_k,
               vecs[i].inj_pos, vecs[i].fin, vecs[i].steps, vecs[i].laps,
               vecs[i].arr);
    end

    // reset mid-move: start from 0 toward 12, pull reset when on tile 6
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tgt_pos = 5'd12;
    tgt_valid = 1'b1;
    @(negedge clk);
    tgt_valid = 1'b0;
    seen6 = 0;
    for (int i = 0; i < 60; i++) begin
      if (cur_pos == 5'd6) begin
        seen6 = 1;
        break;
      end
      @(negedge clk);
    end
    check("midrst_reached6", seen6, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_pos", int'(cur_pos), 0);
    check("midrst_led", int'(led_ring), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_arrived", int'(arrived), 0);
    rst_n = 1'b1;
    n_arr = 0; n_move = 0; n_busy = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (arrived) n_arr++;
      if (busy) n_busy++;
      if (cur_pos != '0) n_move++;
    end
    check("midrst_quiet_arrived", n_arr, 0);
    check("midrst_quiet_busy", n_busy, 0);
    check("midrst_quiet_motion", n_move, 0);
    run_move("post_rst", 2, -1, 0, 2, 2, 0, 1);
    model_pos = 2;

    // randomized moves against the ring model
    for (int r = 0; r < 25; r++) begin
      tgt = int'($urandom_range(0, 31));
      inj_k = -1;
      inj_pos = 0;
      if (tgt < TILES) begin
        steps = (tgt - model_pos + TILES) % TILES;
        laps = (model_pos + steps >= TILES) ? 1 : 0;
        fin = tgt;
        arr = 1;
        if ($urandom_range(0, 1) == 1) begin
          inj_k = (steps == 0) ? 0 : int'($urandom_range(1, steps * STEP_DIV));
          inj_pos = int'($urandom_range(0, 31));
        end
      end else begin
        steps = 0;
        laps = 0;
        fin = model_pos;
        arr = 0;
      end
      run_move($sformatf("rnd%0d", r), tgt, inj_k, inj_pos, fin, steps, laps, arr);
      model_pos = fin;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
